// File: rtl/wb_retire_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_retire_stage_pkg
// Description : Shared load funct3 encodings, trace record layout and the
//               load-data extraction helper for the write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_retire_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int TRACE_W = 69;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_rec_t;

    // Align and extend a load; unknown load encodings return the full word.
    function automatic logic [31:0] load_extract(
        input logic [31:0] data,
        input logic [1:0]  addr_lo,
        input logic [2:0]  funct3
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        case (addr_lo)
            2'd0:    v_byte = data[7:0];
            2'd1:    v_byte = data[15:8];
            2'd2:    v_byte = data[23:16];
            default: v_byte = data[31:24];
        endcase
        v_half = addr_lo[1] ? data[31:16] : data[15:0];
        case (funct3)
            F3_LB:   v_res = {{24{v_byte[7]}}, v_byte};
            F3_LBU:  v_res = {24'd0, v_byte};
            F3_LH:   v_res = {{16{v_half[15]}}, v_half};
            F3_LHU:  v_res = {16'd0, v_half};
            F3_LW:   v_res = data;
            default: v_res = data;
        endcase
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_fifo
// Description : Synchronous FIFO with extra-MSB pointers; never overwrites,
//               a push into a full FIFO is accepted only with a same-cycle pop.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int          c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_retire_stage
// Description : Write-back/retire stage: load alignment, register-file write,
//               performance counters and a retire trace FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int TRACE_DEPTH = 4,
    parameter int TRACE_EN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid_i,
    input  logic [31:0] wb_pc_i,
    input  logic        wb_is_load_i,
    input  logic        wb_is_store_i,
    input  logic [31:0] wb_data_i,
    input  logic [1:0]  wb_addr_lo_i,
    input  logic [2:0]  wb_funct3_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        perf_clear_i,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_rd,
    output logic [31:0] trace_data,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
    output logic [31:0] trace_drop_cnt
);

    logic [31:0] w_ext_data;
    logic        w_trace_drop;

    logic        r_rf_wen;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic [31:0] r_cycle_cnt;
    logic [31:0] r_inst_cnt;
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;
    logic [31:0] r_drop_cnt;

    assign w_ext_data = wb_is_load_i ? load_extract(wb_data_i, wb_addr_lo_i, wb_funct3_i)
                                     : wb_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else begin
            r_rf_wen <= wb_valid_i && (wb_rd_i != 5'd0);
            if (wb_valid_i) begin
                r_rf_waddr <= wb_rd_i;
                r_rf_wdata <= w_ext_data;
            end
        end
    end

    assign rf_wen   = r_rf_wen;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    // Clear beats any same-cycle increment; the drop counter saturates.
    always_ff @(posedge clk) begin
        if (rst || perf_clear_i) begin
            r_cycle_cnt <= 32'd0;
            r_inst_cnt  <= 32'd0;
            r_load_cnt  <= 32'd0;
            r_store_cnt <= 32'd0;
            r_drop_cnt  <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (wb_valid_i) begin
                r_inst_cnt <= r_inst_cnt + 32'd1;
                if (wb_is_load_i) begin
                    r_load_cnt <= r_load_cnt + 32'd1;
                end
                if (wb_is_store_i) begin
                    r_store_cnt <= r_store_cnt + 32'd1;
                end
            end
            if (w_trace_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt      = r_cycle_cnt;
    assign inst_cnt       = r_inst_cnt;
    assign load_cnt       = r_load_cnt;
    assign store_cnt      = r_store_cnt;
    assign trace_drop_cnt = r_drop_cnt;

    generate
        if (TRACE_EN != 0) begin : g_trace
            trace_rec_t w_push_rec;
            trace_rec_t w_head_rec;
            logic       w_full;
            logic       w_empty;
            logic       w_pop;

            assign w_push_rec.pc   = wb_pc_i;
            assign w_push_rec.rd   = wb_rd_i;
            assign w_push_rec.data = (wb_rd_i != 5'd0) ? w_ext_data : 32'd0;

            assign w_pop        = !w_empty && trace_ready;
            assign w_trace_drop = wb_valid_i && w_full && !w_pop;

            wb_trace_fifo #(
                .DEPTH (TRACE_DEPTH),
                .WIDTH (TRACE_W)
            ) u_trace_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (wb_valid_i),
                .i_wdata (w_push_rec),
                .i_pop   (w_pop),
                .o_rdata (w_head_rec),
                .o_full  (w_full),
                .o_empty (w_empty)
            );

            // Gate the head so an empty FIFO presents all-zero outputs.
            assign trace_valid = !w_empty;
            assign trace_pc    = w_empty ? 32'd0 : w_head_rec.pc;
            assign trace_rd    = w_empty ? 5'd0  : w_head_rec.rd;
            assign trace_data  = w_empty ? 32'd0 : w_head_rec.data;
        end else begin : g_no_trace
            assign w_trace_drop = 1'b0;
            assign trace_valid  = 1'b0;
            assign trace_pc     = 32'd0;
            assign trace_rd     = 5'd0;
            assign trace_data   = 32'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_retire_stage
// Description : Directed self-checking bench for wb_retire_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_retire_stage;

    logic        clk;
    logic        rst;
    logic        wb_valid_i;
    logic [31:0] wb_pc_i;
    logic        wb_is_load_i;
    logic        wb_is_store_i;
    logic [31:0] wb_data_i;
    logic [1:0]  wb_addr_lo_i;
    logic [2:0]  wb_funct3_i;
    logic [4:0]  wb_rd_i;
    logic        perf_clear_i;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
    logic [31:0] trace_drop_cnt;

    int r_checks;
    int r_errors;

    wb_retire_stage #(
        .TRACE_DEPTH (4),
        .TRACE_EN    (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid_i     (wb_valid_i),
        .wb_pc_i        (wb_pc_i),
        .wb_is_load_i   (wb_is_load_i),
        .wb_is_store_i  (wb_is_store_i),
        .wb_data_i      (wb_data_i),
        .wb_addr_lo_i   (wb_addr_lo_i),
        .wb_funct3_i    (wb_funct3_i),
        .wb_rd_i        (wb_rd_i),
        .perf_clear_i   (perf_clear_i),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_rd       (trace_rd),
        .trace_data     (trace_data),
        .cycle_cnt      (cycle_cnt),
        .inst_cnt       (inst_cnt),
        .load_cnt       (load_cnt),
        .store_cnt      (store_cnt),
        .trace_drop_cnt (trace_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, after the capturing posedge.
    task automatic retire(input logic [31:0] pc, input logic ld, input logic st,
                          input logic [31:0] data, input logic [1:0] alo,
                          input logic [2:0] f3, input logic [4:0] rd);
        wb_valid_i    = 1'b1;
        wb_pc_i       = pc;
        wb_is_load_i  = ld;
        wb_is_store_i = st;
        wb_data_i     = data;
        wb_addr_lo_i  = alo;
        wb_funct3_i   = f3;
        wb_rd_i       = rd;
        @(negedge clk);
        wb_valid_i    = 1'b0;
        wb_is_load_i  = 1'b0;
        wb_is_store_i = 1'b0;
    endtask

    logic [31:0] exp_pc [4];

    initial begin
        r_checks      = 0;
        r_errors      = 0;
        rst           = 1'b1;
        wb_valid_i    = 1'b0;
        wb_pc_i       = 32'd0;
        wb_is_load_i  = 1'b0;
        wb_is_store_i = 1'b0;
        wb_data_i     = 32'd0;
        wb_addr_lo_i  = 2'd0;
        wb_funct3_i   = 3'd0;
        wb_rd_i       = 5'd0;
        perf_clear_i  = 1'b0;
        trace_ready   = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_rf_wen", {31'd0, rf_wen}, 32'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);
        check("reset_trace_valid", {31'd0, trace_valid}, 32'd0);
        check("reset_cycle_cnt", cycle_cnt, 32'd0);
        check("reset_inst_cnt", inst_cnt, 32'd0);
        check("reset_drop_cnt", trace_drop_cnt, 32'd0);
        rst = 1'b0;

        // LB sign extension from byte 3
        retire(32'h100, 1, 0, 32'h80FF7F01, 2'd3, 3'b000, 5'd5);
        check("lb_wen", {31'd0, rf_wen}, 32'd1);
        check("lb_waddr", {27'd0, rf_waddr}, 32'd5);
        check("lb_wdata", rf_wdata, 32'hFFFFFF80);
        check("lb_cycle_cnt", cycle_cnt, 32'd1);
        check("lb_trace_valid", {31'd0, trace_valid}, 32'd1);
        check("lb_trace_pc", trace_pc, 32'h100);
        check("lb_trace_data", trace_data, 32'hFFFFFF80);

        retire(32'h104, 1, 0, 32'hBEEF1234, 2'd2, 3'b101, 5'd7);
        check("lhu_wdata", rf_wdata, 32'h0000BEEF);
        check("lhu_waddr", {27'd0, rf_waddr}, 32'd7);
        retire(32'h108, 1, 0, 32'hBEEF1234, 2'd2, 3'b001, 5'd7);
        check("lh_wdata", rf_wdata, 32'hFFFFBEEF);
        retire(32'h10C, 1, 0, 32'hBEEF1234, 2'd3, 3'b101, 5'd7);
        check("lhu_alo3_wdata", rf_wdata, 32'h0000BEEF);
        retire(32'h110, 1, 0, 32'h80FF7F01, 2'd2, 3'b100, 5'd8);
        check("lbu_wdata", rf_wdata, 32'h000000FF);
        retire(32'h114, 1, 0, 32'hCAFEF00D, 2'd1, 3'b110, 5'd9);
        check("load_f3_110_wdata", rf_wdata, 32'hCAFEF00D);

        // rd=0 retire: no write, trace data forced to zero
        retire(32'h118, 0, 0, 32'hDEADBEEF, 2'd0, 3'b000, 5'd0);
        check("rd0_wen", {31'd0, rf_wen}, 32'd0);
        check("rd0_inst_cnt", inst_cnt, 32'd7);
        check("rd0_load_cnt", load_cnt, 32'd6);
        check("rd0_trace_pc", trace_pc, 32'h118);
        check("rd0_trace_data", trace_data, 32'd0);

        // ALU with funct3=000 must not be treated as LB
        retire(32'h11C, 0, 0, 32'h12345678, 2'd3, 3'b000, 5'd3);
        check("alu_wen", {31'd0, rf_wen}, 32'd1);
        check("alu_wdata", rf_wdata, 32'h12345678);
        @(negedge clk);
        check("hold_wen", {31'd0, rf_wen}, 32'd0);
        check("hold_waddr", {27'd0, rf_waddr}, 32'd3);
        check("hold_wdata", rf_wdata, 32'h12345678);
        check("drained_trace_valid", {31'd0, trace_valid}, 32'd0);

        // Clear wins over a same-cycle retire
        perf_clear_i = 1'b1;
        retire(32'h120, 1, 1, 32'h0, 2'd0, 3'b010, 5'd1);
        perf_clear_i = 1'b0;
        check("clr_cycle_cnt", cycle_cnt, 32'd0);
        check("clr_inst_cnt", inst_cnt, 32'd0);
        check("clr_load_cnt", load_cnt, 32'd0);
        check("clr_store_cnt", store_cnt, 32'd0);

        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) retire(32'h200 + i, 1, 0, 32'h0, 2'd0, 3'b010, 5'd1);
        for (int i = 0; i < 2; i++) retire(32'h210 + i, 0, 1, 32'h0, 2'd0, 3'b010, 5'd0);
        check("cnt_cycle_cnt", cycle_cnt, 32'd15);
        check("cnt_inst_cnt", inst_cnt, 32'd5);
        check("cnt_load_cnt", load_cnt, 32'd3);
        check("cnt_store_cnt", store_cnt, 32'd2);

        // Fill the FIFO with six retires, consumer stalled
        @(negedge clk);
        trace_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            retire(32'h1000 + 32'(i) * 4, 0, 0, 32'hA0 + 32'(i), 2'd0, 3'b000, 5'(i + 1));
        check("full_trace_valid", {31'd0, trace_valid}, 32'd1);
        check("full_head_pc", trace_pc, 32'h1000);
        check("full_head_rd", {27'd0, trace_rd}, 32'd1);
        check("full_head_data", trace_data, 32'hA0);
        check("full_drop_cnt", trace_drop_cnt, 32'd2);

        // Full FIFO with simultaneous push and pop
        trace_ready = 1'b1;
        retire(32'h3000, 0, 0, 32'h55, 2'd0, 3'b000, 5'd10);
        check("pushpop_drop_cnt", trace_drop_cnt, 32'd2);
        exp_pc[0] = 32'h1004;
        exp_pc[1] = 32'h1008;
        exp_pc[2] = 32'h100C;
        exp_pc[3] = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", {31'd0, trace_valid}, 32'd1);
            check("drain_pc", trace_pc, exp_pc[i]);
            @(negedge clk);
        end
        check("drain_empty", {31'd0, trace_valid}, 32'd0);
        check("drain_drop_cnt", trace_drop_cnt, 32'd2);

        // Reset in the middle of a burst
        trace_ready = 1'b0;
        retire(32'h4000, 0, 0, 32'h1, 2'd0, 3'b000, 5'd4);
        retire(32'h4004, 0, 0, 32'h2, 2'd0, 3'b000, 5'd4);
        check("burst_trace_valid", {31'd0, trace_valid}, 32'd1);
        check("burst_wen", {31'd0, rf_wen}, 32'd1);
        rst = 1'b1;
        retire(32'h4008, 0, 0, 32'h3, 2'd0, 3'b000, 5'd9);
        check("rst_mid_wen", {31'd0, rf_wen}, 32'd0);
        check("rst_mid_trace_valid", {31'd0, trace_valid}, 32'd0);
        check("rst_mid_inst_cnt", inst_cnt, 32'd0);
        check("rst_mid_drop_cnt", trace_drop_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
